// File: rtl/mem_axil_master.sv
// Single-outstanding AXI4-Lite master for core load/store/fetch requests, 32- or 64-bit data bus.
// Define MEM_TIMEOUT_EN to build the bus watchdog (limit TIMEOUT_CYCLES).
module mem_axil_master #(
   parameter int ADDR_W         = 32'sd32,
   parameter int DATA_W         = 32'sd32,
   parameter int TIMEOUT_CYCLES = 32'sd255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_instr,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic                  bvalid,
   input  logic [1:0]            bresp,
   output logic                  bready,
   output logic [ADDR_W-1:0]     araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic                  rvalid,
   input  logic [1:0]            rresp,
   input  logic [DATA_W-1:0]     rdata,
   output logic                  rready
);

   localparam int   STRB_W = DATA_W / 32'sd8;
   localparam int   LANE_W = $clog2(STRB_W);
   localparam logic NARROW = (DATA_W == 32'sd32);

   if ((DATA_W != 32'sd32) && (DATA_W != 32'sd64)) begin : g_bad_data_w
      $error("mem_axil_master: DATA_W must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 32'sd1) begin : g_bad_timeout
      $error("mem_axil_master: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t              state_r, next_state_s;
   logic [1:0]          size_r, size_s;
   logic                signed_r, signed_s;
   logic [LANE_W-1:0]   lane_r, lane_s, req_lane_s;
   logic                aw_done_r, aw_done_s, w_done_r, w_done_s;
   logic                aw_fire_s, w_fire_s;
   logic                req_ready_r, req_ready_s;
   logic                rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
   logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
   logic [ADDR_W-1:0]   awaddr_r, awaddr_s, araddr_r, araddr_s, line_addr_s;
   logic [2:0]          awprot_r, awprot_s, arprot_r, arprot_s;
   logic                awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
   logic                arvalid_r, arvalid_s, rready_r, rready_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [STRB_W-1:0]   wstrb_r, wstrb_s;

`ifdef MEM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 32'sd1);
   logic [TO_W-1:0] wd_cnt_r, wd_cnt_s;
   logic            busy_s, timeout_s;
`endif

   function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size);
      logic [2:0] mask;
      case (size)
         2'd0:    mask = 3'b000;
         2'd1:    mask = 3'b001;
         2'd2:    mask = 3'b011;
         2'd3:    mask = 3'b111;
         default: mask = 3'b000;
      endcase
      return ((low & mask) != 3'b000) || ((size == 2'd3) && NARROW);
   endfunction

   function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size,
                                                  input logic [LANE_W-1:0] lane);
      logic [STRB_W-1:0] base;
      int                nbytes;
      nbytes = 32'sd1 << size;
      for (int i = 0; i < STRB_W; i++) begin
         base[i] = (i < nbytes);
      end
      return base << lane;
   endfunction

   // Truncate the lane-aligned word to the access size, then sign/zero extend.
   function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] size,
                                                    input logic sgn);
      logic [DATA_W-1:0] res;
      logic              fill;
      int                nbits;
      nbits = 32'sd8 << size;
      if (nbits > DATA_W) begin
         nbits = DATA_W;
      end else begin
         nbits = nbits;
      end
      fill = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i == nbits - 32'sd1) begin
            fill = sgn & raw[i];
         end else begin
            fill = fill;
         end
      end
      for (int i = 0; i < DATA_W; i++) begin
         res[i] = (i < nbits) ? raw[i] : fill;
      end
      return res;
   endfunction

   assign req_lane_s  = req_addr[LANE_W-1:0];
   assign line_addr_s = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
   assign aw_fire_s   = awvalid_r & awready;
   assign w_fire_s    = wvalid_r & wready;

   // Next-state and next-output logic; every bus output is registered from here
   always_comb begin
      next_state_s = state_r;
      size_s       = size_r;
      signed_s     = signed_r;
      lane_s       = lane_r;
      aw_done_s    = aw_done_r;
      w_done_s     = w_done_r;
      awaddr_s     = awaddr_r;
      awprot_s     = awprot_r;
      araddr_s     = araddr_r;
      arprot_s     = arprot_r;
      wdata_s      = wdata_r;
      wstrb_s      = wstrb_r;
      awvalid_s    = awvalid_r;
      wvalid_s     = wvalid_r;
      bready_s     = bready_r;
      arvalid_s    = arvalid_r;
      rready_s     = rready_r;
      rsp_valid_s  = 1'b0;
      rsp_err_s    = 1'b0;
      rsp_rdata_s  = '0;
`ifdef MEM_TIMEOUT_EN
      wd_cnt_s     = '0;
      busy_s       = 1'b0;
      timeout_s    = 1'b0;
`endif

      case (state_r)
         IDLE: begin
            if (req_valid && req_ready_r) begin
               size_s   = req_size;
               signed_s = req_signed;
               lane_s   = req_lane_s;
               if (is_misaligned(req_addr[2:0], req_size)) begin
                  next_state_s = RESP;
                  rsp_valid_s  = 1'b1;
                  rsp_err_s    = 1'b1;
               end else if (req_we) begin
                  next_state_s = WR_REQ;
                  awaddr_s     = line_addr_s;
                  awprot_s     = {req_instr, 2'b00};
                  wdata_s      = req_wdata << {req_lane_s, 3'b000};
                  wstrb_s      = lane_strb(req_size, req_lane_s);
                  awvalid_s    = 1'b1;
                  wvalid_s     = 1'b1;
                  aw_done_s    = 1'b0;
                  w_done_s     = 1'b0;
               end else begin
                  next_state_s = RD_REQ;
                  araddr_s     = line_addr_s;
                  arprot_s     = {req_instr, 2'b00};
                  arvalid_s    = 1'b1;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         WR_REQ: begin
            if (aw_fire_s) begin
               awvalid_s = 1'b0;
               aw_done_s = 1'b1;
            end else begin
               aw_done_s = aw_done_r;
            end
            if (w_fire_s) begin
               wvalid_s = 1'b0;
               w_done_s = 1'b1;
            end else begin
               w_done_s = w_done_r;
            end
            if ((aw_done_r || aw_fire_s) && (w_done_r || w_fire_s)) begin
               next_state_s = WR_RESP;
               bready_s     = 1'b1;
            end else begin
               next_state_s = WR_REQ;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               next_state_s = RESP;
               bready_s     = 1'b0;
               rsp_valid_s  = 1'b1;
               rsp_err_s    = (bresp != 2'b00);
            end else begin
               next_state_s = WR_RESP;
            end
         end
         RD_REQ: begin
            if (arready) begin
               next_state_s = RD_DATA;
               arvalid_s    = 1'b0;
               rready_s     = 1'b1;
            end else begin
               next_state_s = RD_REQ;
            end
         end
         RD_DATA: begin
            if (rvalid) begin
               next_state_s = RESP;
               rready_s     = 1'b0;
               rsp_valid_s  = 1'b1;
               rsp_err_s    = (rresp != 2'b00);
               if (rresp == 2'b00) begin
                  rsp_rdata_s = load_extend(rdata >> {lane_r, 3'b000}, size_r, signed_r);
               end else begin
                  rsp_rdata_s = '0;
               end
            end else begin
               next_state_s = RD_DATA;
            end
         end
         RESP: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
            awvalid_s    = 1'b0;
            wvalid_s     = 1'b0;
            bready_s     = 1'b0;
            arvalid_s    = 1'b0;
            rready_s     = 1'b0;
         end
      endcase

`ifdef MEM_TIMEOUT_EN
      // Watchdog overrides whatever the channel logic decided this cycle.
      busy_s    = (state_r == WR_REQ) || (state_r == WR_RESP) ||
                  (state_r == RD_REQ) || (state_r == RD_DATA);
      timeout_s = busy_s && (wd_cnt_r == TO_W'(TIMEOUT_CYCLES - 32'sd1));
      if (timeout_s) begin
         next_state_s = RESP;
         awvalid_s    = 1'b0;
         wvalid_s     = 1'b0;
         bready_s     = 1'b0;
         arvalid_s    = 1'b0;
         rready_s     = 1'b0;
         rsp_valid_s  = 1'b1;
         rsp_err_s    = 1'b1;
         rsp_rdata_s  = '0;
         wd_cnt_s     = '0;
      end else if (busy_s) begin
         wd_cnt_s = wd_cnt_r + TO_W'(1);
      end else begin
         wd_cnt_s = '0;
      end
`endif

      req_ready_s = (next_state_s == IDLE);
   end

   // State, latched request fields and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         size_r      <= 2'b00;
         signed_r    <= 1'b0;
         lane_r      <= '0;
         aw_done_r   <= 1'b0;
         w_done_r    <= 1'b0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= '0;
         awaddr_r    <= '0;
         awprot_r    <= 3'b000;
         araddr_r    <= '0;
         arprot_r    <= 3'b000;
         wdata_r     <= '0;
         wstrb_r     <= '0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         wd_cnt_r    <= '0;
`endif
      end else begin
         state_r     <= next_state_s;
         size_r      <= size_s;
         signed_r    <= signed_s;
         lane_r      <= lane_s;
         aw_done_r   <= aw_done_s;
         w_done_r    <= w_done_s;
         req_ready_r <= req_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_err_r   <= rsp_err_s;
         rsp_rdata_r <= rsp_rdata_s;
         awaddr_r    <= awaddr_s;
         awprot_r    <= awprot_s;
         araddr_r    <= araddr_s;
         arprot_r    <= arprot_s;
         wdata_r     <= wdata_s;
         wstrb_r     <= wstrb_s;
         awvalid_r   <= awvalid_s;
         wvalid_r    <= wvalid_s;
         bready_r    <= bready_s;
         arvalid_r   <= arvalid_s;
         rready_r    <= rready_s;
`ifdef MEM_TIMEOUT_EN
         wd_cnt_r    <= wd_cnt_s;
`endif
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_rdata = rsp_rdata_r;
   assign awaddr    = awaddr_r;
   assign awprot    = awprot_r;
   assign awvalid   = awvalid_r;
   assign wdata     = wdata_r;
   assign wstrb     = wstrb_r;
   assign wvalid    = wvalid_r;
   assign bready    = bready_r;
   assign araddr    = araddr_r;
   assign arprot    = arprot_r;
   assign arvalid   = arvalid_r;
   assign rready    = rready_r;

endmodule
